axi4_wr_arbiter: RTL and testbench

// Round-robin arbiter sharing one AXI4 write path (AW/W/B) between NUM_REQ masters.

---
 rtl/axi4_wr_arbiter.sv | 158 +++++++++++++++
 tb/tb_axi4_wr_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wr_arbiter.sv
// Round-robin arbiter giving NUM_REQ AXI4 masters exclusive AW->W->B ownership of one slave write port.
// Optional AXI_ARB_LEN_CHECK_EN adds a sticky W-beat versus awlen mismatch flag on len_err.
module axi4_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 18,
  localparam int AW_W = ID_WIDTH + ADDR_WIDTH + 13,
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8 + 1,
  localparam int B_W  = ID_WIDTH + 2
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  input  logic [NUM_REQ-1:0]        s_awvalid,
  output logic [NUM_REQ-1:0]        s_awready,
  input  logic [NUM_REQ*AW_W-1:0]   s_aw,
  input  logic [NUM_REQ-1:0]        s_wvalid,
  output logic [NUM_REQ-1:0]        s_wready,
  input  logic [NUM_REQ*W_W-1:0]    s_w,
  output logic [NUM_REQ-1:0]        s_bvalid,
  input  logic [NUM_REQ-1:0]        s_bready,
  output logic [B_W-1:0]            s_b,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [AW_W-1:0]           m_aw,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [W_W-1:0]            m_w,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [B_W-1:0]            m_b,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      len_err
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]      r_gidx, w_gidx_nxt;
  logic [IW-1:0]      r_last, w_last_nxt;
  logic [IW-1:0]      w_win;
  logic               w_aw_hs, w_w_hs, w_b_hs;

  // Scan from furthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    w_win = r_last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (s_awvalid[IW'((int'(r_last) + k) % NUM_REQ)])
        w_win = IW'((int'(r_last) + k) % NUM_REQ);
    end
  end

  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_aw      = '0;
    m_w       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        m_aw = s_aw[k*AW_W +: AW_W];
        m_w  = s_w[k*W_W +: W_W];
      end
    end
    case (r_state)
      ST_ADDR: begin
        m_awvalid = |(s_awvalid & r_grant);
        s_awready = r_grant & {NUM_REQ{m_awready}};
      end
      ST_DATA: begin
        m_wvalid = |(s_wvalid & r_grant);
        s_wready = r_grant & {NUM_REQ{m_wready}};
      end
      ST_RESP: begin
        m_bready = |(s_bready & r_grant);
        s_bvalid = r_grant & {NUM_REQ{m_bvalid}};
      end
      default: ;
    endcase
  end

  assign s_b     = m_b;
  assign grant   = r_grant;
  assign w_aw_hs = m_awvalid & m_awready;
  assign w_w_hs  = m_wvalid & m_wready;
  assign w_b_hs  = m_bvalid & m_bready;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: if (|s_awvalid) begin
        w_state_nxt = ST_ADDR;
        w_gidx_nxt  = w_win;
        w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
      end
      ST_ADDR: if (w_aw_hs) w_state_nxt = ST_DATA;
      ST_DATA: if (w_w_hs && m_w[0]) w_state_nxt = ST_RESP;
      ST_RESP: if (w_b_hs) begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_last_nxt  = r_gidx;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IW'(NUM_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
    end
  end

`ifdef AXI_ARB_LEN_CHECK_EN
  logic [8:0] r_beat_cnt;
  logic [7:0] r_awlen;
  logic       r_len_err;
  logic [8:0] w_beat_now;

  assign w_beat_now = r_beat_cnt + 9'd1;

  // The mismatching burst is still forwarded; only the flag records it.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_beat_cnt <= '0;
      r_awlen    <= '0;
      r_len_err  <= 1'b0;
    end else if (w_aw_hs) begin
      r_beat_cnt <= '0;
      r_awlen    <= m_aw[12:5];
    end else if (w_w_hs) begin
      r_beat_cnt <= w_beat_now;
      if (m_w[0] && (w_beat_now != ({1'b0, r_awlen} + 9'd1)))
        r_len_err <= 1'b1;
    end
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed bench for axi4_wr_arbiter: cycle vector table plus contention, fairness, reset and length sequences.
module tb_axi4_wr_arbiter;
  logic        clk_clk;
  logic        reset_reset_n;
  logic [1:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready, grant;
  logic [93:0] s_aw;
  logic [73:0] s_w;
  logic [19:0] s_b, m_b;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, len_err;
  logic [46:0] m_aw;
  logic [36:0] m_w;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] aw_len [2];

`ifdef AXI_ARB_LEN_CHECK_EN
  localparam logic LE_EXP = 1'b1;
`else
  localparam logic LE_EXP = 1'b0;
`endif

  axi4_wr_arbiter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
    .grant(grant), .len_err(len_err)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic [1:0]  awv;
    logic [1:0]  wv;
    logic        wlast;
    logic        awr;
    logic        wr;
    logic        bv;
    logic [1:0]  brdy;
    logic [10:0] exp;   // {grant, m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready}
  } vec_t;

  vec_t tbl [24];

  function automatic logic [46:0] mk_aw(input int m, input logic [7:0] len);
    return {18'(m + 1), 16'(32'h0004 + m * 256), len, 3'd2, 2'b01};
  endfunction

  function automatic logic [31:0] wdat(input int m);
    return (m == 0) ? 32'h02020202 : 32'h13131313;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_payload(input logic wl);
    s_aw = {mk_aw(1, aw_len[1]), mk_aw(0, aw_len[0])};
    s_w  = {wdat(1), 4'hf, wl, wdat(0), 4'hf, wl};
  endtask

  task automatic tick();
    @(posedge clk_clk);
    @(negedge clk_clk);
  endtask

  function automatic logic [10:0] outs();
    return {grant, m_awvalid, s_awready, m_wvalid, s_wready, s_bvalid, m_bready};
  endfunction

  task automatic do_reset();
    reset_reset_n = 1'b0;
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    m_b = {18'h00001, 2'b00};
    aw_len[0] = 8'd0; aw_len[1] = 8'd0;
    drive_payload(1'b0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
  endtask

  // One full transaction owned by master m; other master keeps W valid to expose any interleave.
  task automatic do_txn(input int m, input int beats, input logic [1:0] mask_pre,
                        input logic [1:0] mask_post, input string tag);
    logic [1:0] oh;
    oh = 2'(1 << m);
    s_awvalid = mask_pre; s_wvalid = '0; s_bready = '0;
    m_bvalid = 1'b0; m_awready = 1'b1; m_wready = 1'b1;
    drive_payload(1'b0);
    #1 chk({tag, " idle grant"}, 64'(grant), 64'd0);
    tick();
    #1 chk({tag, " grant"}, 64'(grant), 64'(oh));
    chk({tag, " m_aw"}, 64'(m_aw), 64'(mk_aw(m, aw_len[m])));
    tick();
    s_awvalid = mask_post;
    for (int b = 0; b < beats; b++) begin
      s_wvalid = 2'b11;
      drive_payload(b == beats - 1);
      #1 chk($sformatf("%s beat%0d wready", tag, b), 64'(s_wready), 64'(oh));
      chk($sformatf("%s beat%0d m_w", tag, b), 64'(m_w), 64'({wdat(m), 4'hf, 1'(b == beats - 1)}));
      tick();
    end
    s_wvalid = '0; m_bvalid = 1'b1; s_bready = 2'b11;
    #1 chk({tag, " bvalid"}, 64'(s_bvalid), 64'(oh));
    tick();
    m_bvalid = 1'b0; s_bready = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // awv  wv   wl   awr  wr   bv   brdy   grant m_awv s_awr m_wv s_wr s_bv m_br
    tbl[0]  = {2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b00_0_00_0_00_00_0};
    tbl[1]  = {2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b01_1_01_0_00_00_0};
    tbl[2]  = {2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 11'b01_0_00_1_01_00_0};
    tbl[3]  = {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 11'b01_0_00_0_00_01_1};
    tbl[4]  = {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b00_0_00_0_00_00_0};
    tbl[5]  = {2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b00_0_00_0_00_00_0};
    tbl[6]  = {2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 11'b10_1_00_0_00_00_0};
    tbl[7]  = {2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b10_1_10_0_00_00_0};
    tbl[8]  = {2'b01, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b10_0_00_1_10_00_0};
    tbl[9]  = {2'b01, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 11'b10_0_00_1_00_00_0};
    tbl[10] = {2'b01, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 11'b10_0_00_1_10_00_0};
    tbl[11] = {2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b11, 11'b10_0_00_0_00_00_1};
    tbl[12] = {2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 11'b10_0_00_0_00_10_0};
    tbl[13] = {2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 11'b10_0_00_0_00_10_1};
    tbl[14] = {2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b00_0_00_0_00_00_0};
    tbl[15] = {2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 11'b01_1_01_0_00_00_0};
    tbl[16] = {2'b00, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 11'b01_0_00_1_01_00_0};
    tbl[17] = {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 11'b01_0_00_0_00_01_1};
    tbl[18] = {2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b00_0_00_0_00_00_0};
    tbl[19] = {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b10_0_10_0_00_00_0};
    tbl[20] = {2'b10, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b10_1_10_0_00_00_0};
    tbl[21] = {2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 11'b10_0_00_1_10_00_0};
    tbl[22] = {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 11'b10_0_00_0_00_10_1};
    tbl[23] = {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'b00_0_00_0_00_00_0};

    // Reset state with every input asserted: outputs must stay quiet.
    do_reset();
    reset_reset_n = 1'b0;
    s_awvalid = 2'b11; s_wvalid = 2'b11; s_bready = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
    tick();
    #1 chk("reset outputs", 64'(outs()), 64'd0);
    chk("reset len_err", 64'(len_err), 64'd0);
    s_awvalid = '0; s_wvalid = '0; s_bready = '0;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
    reset_reset_n = 1'b1;
    tick();
    #1 chk("post-release idle", 64'(outs()), 64'd0);
    tick();

    for (int i = 0; i < 24; i++) begin
      s_awvalid = tbl[i].awv; s_wvalid = tbl[i].wv;
      m_awready = tbl[i].awr; m_wready = tbl[i].wr;
      m_bvalid = tbl[i].bv; s_bready = tbl[i].brdy;
      drive_payload(tbl[i].wlast);
      #1 chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
      if (tbl[i].exp[8])
        chk($sformatf("vec%0d m_aw", i), 64'(m_aw), 64'(mk_aw(tbl[i].exp[10] ? 1 : 0, 8'd0)));
      if (tbl[i].exp[5])
        chk($sformatf("vec%0d m_w", i), 64'(m_w),
            64'({wdat(tbl[i].exp[10] ? 1 : 0), 4'hf, tbl[i].wlast}));
      if (tbl[i].exp[2:1] != 2'b00)
        chk($sformatf("vec%0d s_b", i), 64'(s_b), 64'({18'h00001, 2'b00}));
      tick();
    end

    // Contention: both masters hold 8-beat requests; ownership alternates M0,M1,M0,M1.
    do_reset();
    aw_len[0] = 8'd7; aw_len[1] = 8'd7;
    do_txn(0, 8, 2'b11, 2'b11, "ct0");
    do_txn(1, 8, 2'b11, 2'b11, "ct1");
    do_txn(0, 8, 2'b11, 2'b11, "ct2");
    do_txn(1, 8, 2'b11, 2'b11, "ct3");
    chk("contention len_err", 64'(len_err), 64'd0);

    // Fairness: M0 asks while M1 owns the path and is served next despite M1 still asking.
    do_reset();
    aw_len[0] = 8'd0; aw_len[1] = 8'd1;
    do_txn(1, 2, 2'b10, 2'b11, "fa0");
    do_txn(0, 1, 2'b11, 2'b10, "fa1");
    do_txn(1, 2, 2'b10, 2'b00, "fa2");
    chk("fairness len_err", 64'(len_err), 64'd0);

    // Reset during beat 4 of 8 kills every output immediately; M0 wins afterwards.
    do_reset();
    aw_len[0] = 8'd7; aw_len[1] = 8'd7;
    m_awready = 1'b1; m_wready = 1'b1;
    s_awvalid = 2'b01;
    drive_payload(1'b0);
    tick();
    #1 chk("mr grant", 64'(grant), 64'd1);
    tick();
    s_awvalid = 2'b00; s_wvalid = 2'b01;
    repeat (3) tick();
    #1 chk("mr beat4 wready", 64'(s_wready), 64'd1);
    reset_reset_n = 1'b0;
    #1 chk("mr reset outputs", 64'(outs()), 64'd0);
    chk("mr reset m_aw", 64'(m_aw), 64'd0);
    chk("mr reset m_w", 64'(m_w), 64'd0);
    tick();
    reset_reset_n = 1'b1;
    s_wvalid = '0; s_awvalid = 2'b11;
    #1 chk("mr idle after reset", 64'(outs()), 64'd0);
    tick();
    #1 chk("mr regrant M0", 64'(grant), 64'd1);

    // Short burst against awlen=7, then a well-formed one: flag latches and holds.
    do_reset();
    aw_len[0] = 8'd7;
    do_txn(0, 5, 2'b01, 2'b00, "le0");
    chk("len_err short burst", 64'(len_err), 64'(LE_EXP));
    aw_len[0] = 8'd0;
    do_txn(0, 1, 2'b01, 2'b00, "le1");
    chk("len_err sticky", 64'(len_err), 64'(LE_EXP));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
